// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: registered single-cycle ops plus optional iterative shift-add MUL.
// Build with ALU_MUL_EN defined to include the multiplier; otherwise ALU_MUL yields 0 in one cycle.
module alu_exec_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_in_valid,
  output logic            alu_in_ready,
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_a,
  input  logic [XLEN-1:0] alu_b,
  output logic            alu_out_valid,
  input  logic            alu_out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic            alu_busy
);

  localparam int unsigned SHW = $clog2(XLEN);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_SEQ  = 4'd10,
    ALU_MUL  = 4'd11
  } alu_op_e;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_e;

  state_e          state_q, state_d;
  logic            accept;
  logic            is_mul;
  logic            mul_done;
  logic [XLEN-1:0] simple_res;
  logic [XLEN-1:0] mul_res;
  logic [SHW-1:0]  shamt;

  assign alu_in_ready = (state_q == S_IDLE) && (!alu_out_valid || alu_out_ready);
  assign accept       = alu_in_valid && alu_in_ready;
  assign shamt        = alu_b[SHW-1:0];

  always_comb begin
    simple_res = '0;
    case (alu_op_e'(alu_op))
      ALU_ADD:  simple_res = alu_a + alu_b;
      ALU_SUB:  simple_res = alu_a - alu_b;
      ALU_SLL:  simple_res = alu_a << shamt;
      ALU_SRL:  simple_res = alu_a >> shamt;
      ALU_SRA:  simple_res = $signed(alu_a) >>> shamt;
      ALU_SLT:  simple_res = {{(XLEN-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      ALU_SLTU: simple_res = {{(XLEN-1){1'b0}}, (alu_a < alu_b)};
      ALU_SEQ:  simple_res = {{(XLEN-1){1'b0}}, (alu_a == alu_b)};
      ALU_AND:  simple_res = alu_a & alu_b;
      ALU_OR:   simple_res = alu_a | alu_b;
      ALU_XOR:  simple_res = alu_a ^ alu_b;
      default:  simple_res = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  logic [XLEN-1:0] mcand_q;
  logic [XLEN-1:0] mplier_q;
  logic [XLEN-1:0] acc_q;
  logic [SHW-1:0]  count_q;

  assign is_mul   = (alu_op == ALU_MUL);
  assign mul_done = (state_q == S_MUL) && (count_q == '0);
  // Final result must include the add performed on the terminating iteration.
  assign mul_res  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign alu_busy = (state_q == S_MUL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
    end else if (accept && is_mul) begin
      mcand_q  <= alu_a;
      mplier_q <= alu_b;
      acc_q    <= '0;
      count_q  <= SHW'(XLEN - 1);
    end else if (state_q == S_MUL) begin
      acc_q    <= mul_res;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      count_q  <= count_q - SHW'(1);
    end
  end
`else
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
  assign mul_res  = '0;
  assign alu_busy = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && is_mul) state_d = S_MUL;
      S_MUL:   if (mul_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A new single-cycle accept overrides the consume, so valid stays high back-to-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_out_valid <= 1'b0;
      alu_result    <= '0;
    end else if (accept && !is_mul) begin
      alu_out_valid <= 1'b1;
      alu_result    <= simple_res;
    end else if (accept && is_mul) begin
      alu_out_valid <= 1'b0;
    end else if (mul_done) begin
      alu_out_valid <= 1'b1;
      alu_result    <= mul_res;
    end else if (alu_out_valid && alu_out_ready) begin
      alu_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit; MUL scenarios follow the ALU_MUL_EN build option.
module tb_alu_exec_unit;
  localparam int XLEN = 32;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;
  localparam logic [3:0] OP_SEQ  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_in_valid;
  logic            alu_in_ready;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic            alu_out_valid;
  logic            alu_out_ready;
  logic [XLEN-1:0] alu_result;
  logic            alu_busy;

  int errors = 0;
  int checks = 0;

  alu_exec_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .alu_in_valid(alu_in_valid), .alu_in_ready(alu_in_ready),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out_valid(alu_out_valid), .alu_out_ready(alu_out_ready),
    .alu_result(alu_result), .alu_busy(alu_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    int unsigned sh;
    logic [31:0] ones;
    sh = b % 32;
    ones = 32'hFFFF_FFFF;
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLL:  return a << sh;
      OP_SRL:  return a >> sh;
      OP_SRA:  return (a >> sh) | ((a[31] == 1'b1) ? ~(ones >> sh) : 32'h0);
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      OP_SEQ:  return (a == b) ? 32'd1 : 32'd0;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
`ifdef ALU_MUL_EN
      OP_MUL:  return 32'(64'(a) * 64'(b));
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic ordy);
    alu_in_valid  = v;
    alu_op        = op;
    alu_a         = a;
    alu_b         = b;
    alu_out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (alu_out_valid !== 1'b0 || alu_result !== 32'h0 || alu_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b result=%h busy=%b, required 0/00000000/0",
               alu_out_valid, alu_result, alu_busy);
    end
    #10 rst = 1'b0;
    #1;
    checks++;
    if (alu_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, required 1", alu_in_ready);
    end
  endtask

  task automatic test_add_sub();
    drive(1'b1, OP_ADD, 32'hFFFF_FFFF, 32'h1, 1'b1);
    tick();
    checks++;
    if (alu_out_valid !== 1'b1 || alu_result !== 32'h0) begin
      errors++;
      $display("FAIL add_wrap: valid=%b result=%h, required 1/00000000", alu_out_valid, alu_result);
    end
    checks++;
    if (alu_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: got %b, required 1", alu_in_ready);
    end
    drive(1'b1, OP_SUB, 32'h0, 32'h1, 1'b1);
    tick();
    checks++;
    if (alu_out_valid !== 1'b1 || alu_result !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL sub_wrap: valid=%b result=%h, required 1/ffffffff", alu_out_valid, alu_result);
    end
    drive(1'b0, OP_ADD, 32'h0, 32'h0, 1'b1);
    tick();
    checks++;
    if (alu_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_valid: got %b, required 0", alu_out_valid);
    end
  endtask

  task automatic test_shift_cmp();
    logic [3:0]  ops [4] = '{OP_SRA, OP_SRL, OP_SLT, OP_SLTU};
    logic [31:0] as  [4] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bs  [4] = '{32'h24, 32'h24, 32'h1, 32'h1};
    logic [31:0] exp [4] = '{32'hF800_0000, 32'h0800_0000, 32'h1, 32'h0};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ops[i], as[i], bs[i], 1'b1);
      tick();
      checks++;
      if (alu_out_valid !== 1'b1 || alu_result !== exp[i]) begin
        errors++;
        $display("FAIL shift_cmp[%0d]: valid=%b result=%h, required 1/%h",
                 i, alu_out_valid, alu_result, exp[i]);
      end
    end
    drive(1'b0, OP_ADD, 32'h0, 32'h0, 1'b1);
    tick();
  endtask

  task automatic test_backpressure();
    drive(1'b1, OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0);
    tick();
    checks++;
    if (alu_out_valid !== 1'b1 || alu_result !== 32'h00F0_1234) begin
      errors++;
      $display("FAIL bp_and: valid=%b result=%h, required 1/00f01234", alu_out_valid, alu_result);
    end
    drive(1'b1, OP_OR, 32'h1, 32'h2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (alu_in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_ready[%0d]: got %b, required 0", i, alu_in_ready);
      end
      tick();
      checks++;
      if (alu_out_valid !== 1'b1 || alu_result !== 32'h00F0_1234) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b result=%h, required 1/00f01234",
                 i, alu_out_valid, alu_result);
      end
    end
    alu_out_ready = 1'b1;
    #1;
    checks++;
    if (alu_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready: got %b, required 1", alu_in_ready);
    end
    tick();
    checks++;
    if (alu_out_valid !== 1'b1 || alu_result !== 32'h3) begin
      errors++;
      $display("FAIL bp_release_or: valid=%b result=%h, required 1/00000003", alu_out_valid, alu_result);
    end
    drive(1'b0, OP_ADD, 32'h0, 32'h0, 1'b1);
    tick();
  endtask

  task automatic test_mul();
    logic [31:0] as  [2] = '{32'd7, 32'hFFFF_FFFF};
    logic [31:0] bs  [2] = '{32'd6, 32'hFFFF_FFFF};
`ifdef ALU_MUL_EN
    logic [31:0] exp [2] = '{32'd42, 32'h1};
    for (int v = 0; v < 2; v++) begin
      drive(1'b1, OP_MUL, as[v], bs[v], 1'b1);
      tick();
      drive(1'b0, OP_ADD, 32'h0, 32'h0, 1'b1);
      for (int i = 0; i < XLEN; i++) begin
        if (i > 0) tick();
        checks++;
        if (alu_busy !== 1'b1 || alu_in_ready !== 1'b0 || alu_out_valid !== 1'b0) begin
          errors++;
          $display("FAIL mul_iter[%0d][%0d]: busy=%b in_ready=%b valid=%b, required 1/0/0",
                   v, i, alu_busy, alu_in_ready, alu_out_valid);
        end
      end
      tick();
      checks++;
      if (alu_out_valid !== 1'b1 || alu_result !== exp[v] || alu_busy !== 1'b0) begin
        errors++;
        $display("FAIL mul_result[%0d]: valid=%b result=%h busy=%b, required 1/%h/0",
                 v, alu_out_valid, alu_result, alu_busy, exp[v]);
      end
      tick();
    end
`else
    for (int v = 0; v < 2; v++) begin
      drive(1'b1, OP_MUL, as[v], bs[v], 1'b1);
      tick();
      drive(1'b0, OP_ADD, 32'h0, 32'h0, 1'b1);
      checks++;
      if (alu_out_valid !== 1'b1 || alu_result !== 32'h0 || alu_busy !== 1'b0) begin
        errors++;
        $display("FAIL mul_disabled[%0d]: valid=%b result=%h busy=%b, required 1/00000000/0",
                 v, alu_out_valid, alu_result, alu_busy);
      end
      tick();
      checks++;
      if (alu_busy !== 1'b0 || alu_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mul_disabled_idle[%0d]: busy=%b valid=%b, required 0/0", v, alu_busy, alu_out_valid);
      end
    end
`endif
  endtask

  task automatic test_reset_mid_op();
    logic spurious;
`ifdef ALU_MUL_EN
    drive(1'b1, OP_MUL, 32'd5, 32'd9, 1'b1);
    tick();
    drive(1'b0, OP_ADD, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 9; i++) tick();
`else
    drive(1'b1, OP_XOR, 32'hA5, 32'h0F, 1'b0);
    tick();
    drive(1'b0, OP_ADD, 32'h0, 32'h0, 1'b0);
`endif
    #2 rst = 1'b1;
    #1;
    checks++;
    if (alu_out_valid !== 1'b0 || alu_result !== 32'h0 || alu_busy !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset: valid=%b result=%h busy=%b, required 0/00000000/0",
               alu_out_valid, alu_result, alu_busy);
    end
    #3 rst = 1'b0;
    #1;
    checks++;
    if (alu_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midop_ready: got %b, required 1", alu_in_ready);
    end
    spurious = 1'b0;
    for (int i = 0; i < XLEN + 8; i++) begin
      tick();
      if (alu_out_valid !== 1'b0 || alu_busy !== 1'b0) spurious = 1'b1;
    end
    checks++;
    if (spurious !== 1'b0) begin
      errors++;
      $display("FAIL midop_no_result: spurious valid/busy seen=%b, required 0", spurious);
    end
    drive(1'b1, OP_ADD, 32'd2, 32'd3, 1'b1);
    tick();
    checks++;
    if (alu_out_valid !== 1'b1 || alu_result !== 32'd5) begin
      errors++;
      $display("FAIL midop_add: valid=%b result=%h, required 1/00000005", alu_out_valid, alu_result);
    end
    drive(1'b0, OP_ADD, 32'h0, 32'h0, 1'b1);
    tick();
  endtask

  task automatic test_random();
    logic        m_valid;
    logic [31:0] m_result;
    logic        v, ordy, exp_ready;
    logic [3:0]  op;
    logic [31:0] a, b;
    m_valid  = 1'b0;
    m_result = 32'h0;
    for (int n = 0; n < 300; n++) begin
      v  = ($urandom_range(0, 3) != 0);
      op = 4'($urandom_range(0, 15));
`ifdef ALU_MUL_EN
      if (op == OP_MUL) op = OP_SUB;
`endif
      a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      b  = ($urandom_range(0, 7) == 0) ? a : $urandom;
      ordy = ($urandom_range(0, 3) != 0);
      drive(v, op, a, b, ordy);
      #1;
      exp_ready = !m_valid || ordy;
      checks++;
      if (alu_in_ready !== exp_ready) begin
        errors++;
        $display("FAIL rnd_ready[%0d]: got %b, required %b", n, alu_in_ready, exp_ready);
      end
      if (v && exp_ready) begin
        m_valid  = 1'b1;
        m_result = ref_alu(op, a, b);
      end else if (m_valid && ordy) begin
        m_valid = 1'b0;
      end
      tick();
      checks++;
      if (alu_out_valid !== m_valid || (m_valid && alu_result !== m_result)) begin
        errors++;
        $display("FAIL rnd_out[%0d]: op=%0d valid=%b result=%h, required %b/%h",
                 n, op, alu_out_valid, alu_result, m_valid, m_result);
      end
    end
    drive(1'b0, OP_ADD, 32'h0, 32'h0, 1'b1);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, OP_ADD, 32'h0, 32'h0, 1'b0);
    test_reset();
    test_add_sub();
    test_shift_cmp();
    test_backpressure();
    test_mul();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage ALU that consumes the 4-bit `alu_op` produced by the ALU op decoder, together with two operands, and returns a registered result over a valid/ready handshake. All single-cycle operations (ADD, SUB, shifts, compares, logic, SEQ) complete with one-cycle latency. `ALU_MUL` runs on an iterative shift-add multiplier that holds the unit busy for XLEN cycles. The block sits between the decode/operand-select logic and the writeback/branch-resolve logic.

## Interface
- XLEN, 32, operand/result width; must be a power of two ≥ 8
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- alu_in_valid  in  1  operation request
- alu_in_ready  out  1  unit can accept a request this cycle
- alu_op  in  4  operation, encodings per `control_constants.v` (`ALU_*`)
- alu_a  in  XLEN  operand A (rs1)
- alu_b  in  XLEN  operand B (rs2 or immediate)
- alu_out_valid  out  1  alu_result holds a completed result
- alu_out_ready  in  1  consumer takes the result this cycle
- alu_result  out  XLEN  registered result
- alu_busy  out  1  multiplier iteration in progress

## Operation
- Accept on `alu_in_valid && alu_in_ready`. Inputs are sampled only at accept and need not be held afterward.
- `alu_in_ready = (state==IDLE) && (!alu_out_valid || alu_out_ready)`.
- States:
  - IDLE: accepts requests.
  - MUL: iterates.
- Transitions:
  - IDLE→MUL on accept of `ALU_MUL`.
  - MUL→IDLE on the final iteration.
- Results:
  - ADD/SUB: A±B modulo 2^XLEN.
  - AND/OR/XOR: bitwise.
  - SLL/SRL/SRA: shift A by `B[log2(XLEN)-1:0]`. SRA sign-fills.
  - SLT: signed A<B. SLTU: unsigned A<B. SEQ: A==B. Each gives a zero-extended 1 or 0.
  - MUL: low XLEN bits of A×B. The result is identical for signed and unsigned operands.
  - Any other code: result 0, single-cycle.
- MUL datapath:
  - On accept, load multiplicand=A, multiplier=B, accumulator=0, counter=XLEN-1.
  - Each MUL cycle: if `multiplier[0]`, add multiplicand to accumulator. Then shift multiplicand left 1, shift multiplier right 1, decrement counter.
  - On the cycle where counter==0, write the accumulator (including that cycle's add) to `alu_result` and set `alu_out_valid`.
- Output holding: `alu_result` and `alu_out_valid` stay stable until `alu_out_ready` is sampled high while `alu_out_valid` is high.
- Simultaneous output handshake and new non-MUL accept in the same cycle: `alu_out_valid` stays 1 and `alu_result` takes the new value.
- Simultaneous output handshake and new MUL accept: `alu_out_valid` drops to 0.
- `alu_busy` = (state==MUL).

## Timing
- Reset values:
  - state IDLE; `alu_out_valid`=0; `alu_result`=0; `alu_busy`=0; counter=0.
  - `alu_in_ready`=1 once rst deasserts.
- Non-MUL latency: accepted at edge k, `alu_out_valid`=1 after edge k.
- MUL latency: accepted at edge k. `alu_busy`=1 after edges k..k+XLEN-1. `alu_out_valid`=1 after edge k+XLEN. For XLEN=32, 32 cycles.
- Throughput: one non-MUL op per cycle with `alu_out_ready` held high. `alu_in_ready`=0 throughout MUL.
- Reset mid-MUL aborts immediately. No `alu_out_valid` is produced for the aborted operation.
- No combinational path from `alu_a`/`alu_b`/`alu_op` to any output. `alu_in_ready` depends combinationally on `alu_out_ready`.

## Configuration
- `ALU_MUL_EN` defined:
  - The iterative multiplier, MUL state, counter and `alu_busy` are built.
  - `ALU_MUL` behaves as above.
- `ALU_MUL_EN` undefined:
  - No multiplier logic.
  - `ALU_MUL` is treated as an undefined code: single-cycle, result 0.
  - `alu_busy` is tied 0; the state machine never leaves IDLE.

## Test plan
- ADD 0xFFFFFFFF+1, SUB 0-1, `alu_out_ready`=1 → results 0x00000000 then 0xFFFFFFFF, each `alu_out_valid` one cycle after its accept, back-to-back.
- SRA A=0x80000000, B=0x00000024; SRL same operands; SLT A=-1,B=1; SLTU A=-1,B=1 → 0xF8000000, 0x08000000, 1, 0.
- MUL 7×6 and 0xFFFFFFFF×0xFFFFFFFF (`ALU_MUL_EN` defined) → 42 and 0x00000001, each exactly 32 cycles after accept. `alu_in_ready`=0 and `alu_busy`=1 during iteration.
- Backpressure: hold `alu_out_ready`=0 for 5 cycles after an AND result → `alu_result` stable, `alu_in_ready`=0. Release → next op accepted the same cycle.
- Assert rst during MUL cycle 10 → all outputs return to reset values; the next ADD 2+3 yields 5 with normal latency.
- `ALU_MUL_EN` undefined: MUL 7×6 → result 0 one cycle after accept, `alu_busy` never 1.
